seg_scan_ctrl: RTL and testbench

Time-multiplexes four BCD digits onto one shared 7-segment decoder and the four common-anode enables of the board display. It sits between the value-producing logic and the combinational digit decoder. Each digit gets a slot in a fixed scan order. A blanking gap precedes every digit to suppress ghosting. New values are double-buffered and applied only at frame boundaries, so a displayed number never tears mid-frame.

---
 rtl/seg_scan_ctrl_if.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: value-producer inputs and display-side outputs of the 4-digit scan controller.
// master drives en_n/load/digits/dp and observes the display; slave is the controller itself.
interface seg_scan_ctrl_if;
  logic        en_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in_n;
  logic [3:0]  an;
  logic [3:0]  bcd;
  logic        dp_n;
  logic        frame_done;

  modport master (
    output en_n, load, digits_in, dp_in_n,
    input  an, bcd, dp_n, frame_done
  );

  modport slave (
    input  en_n, load, digits_in, dp_in_n,
    output an, bcd, dp_n, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans 4 BCD digits (blank gap then show per slot), double-buffered at frame edges; outputs
// registered, no backpressure (load always accepted). LEADING_ZERO_BLANK_EN: dark leading zeros in SHOW.
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic            clk,
  input logic            reset,
  seg_scan_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam int CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SLOT_CYCLES - BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0]      pend_dig_q, pend_dig_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pend_vld_q, pend_vld_d;
  logic [15:0]      disp_dig_q, disp_dig_d;
  logic [3:0]       disp_dp_q, disp_dp_d;

  logic [3:0]       an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             dp_n_q, dp_n_d;
  logic             frame_done_q, frame_done_d;

  logic             commit;
  logic [3:0]       cur_dig;
  logic             cur_dp_n;
  logic             show_en;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q + CNT_ONE;
    if (bus.en_n) begin
      state_d = ST_IDLE;
      slot_d  = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          slot_d  = 2'd0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            slot_d  = slot_q + 2'd1;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Display buffer only changes while dark (IDLE) or across the frame seam, so a frame never tears.
  assign commit = (state_q == ST_IDLE) ||
                  ((state_q == ST_SHOW) && (slot_q == 2'd3) && (cnt_q == SHOW_LAST));

  always_comb begin
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    disp_dig_d = disp_dig_q;
    disp_dp_d  = disp_dp_q;
    if (bus.load) begin
      pend_dig_d = bus.digits_in;
      pend_dp_d  = bus.dp_in_n;
      pend_vld_d = 1'b1;
    end
    if (commit) begin
      if (bus.load) begin
        disp_dig_d = bus.digits_in;
        disp_dp_d  = bus.dp_in_n;
      end else if (pend_vld_q) begin
        disp_dig_d = pend_dig_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_vld_d = 1'b0;
    end
  end

  assign cur_dig  = disp_dig_d[{slot_d, 2'b00} +: 4];
  assign cur_dp_n = disp_dp_d[slot_d];

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[k]: digit k and all digits above it are zero; digit 0 is never suppressed.
  logic [3:0] lead_zero;

  always_comb begin
    lead_zero    = 4'b0000;
    lead_zero[3] = (disp_dig_d[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_dig_d[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_dig_d[7:4] == 4'd0);
  end

  assign show_en = !(lead_zero[slot_d] && cur_dp_n);
`else
  assign show_en = 1'b1;
`endif

  always_comb begin
    an_d         = 4'b1111;
    bcd_d        = 4'd0;
    dp_n_d       = 1'b1;
    frame_done_d = 1'b0;
    if (state_d != ST_IDLE) begin
      bcd_d  = cur_dig;
      dp_n_d = cur_dp_n;
    end
    if ((state_d == ST_SHOW) && show_en) begin
      an_d = ~(4'b0001 << slot_d);
    end
    frame_done_d = (state_d == ST_SHOW) && (slot_d == 2'd3) && (cnt_d == SHOW_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      slot_q       <= 2'd0;
      cnt_q        <= '0;
      pend_dig_q   <= 16'h0000;
      pend_dp_q    <= 4'b1111;
      pend_vld_q   <= 1'b0;
      disp_dig_q   <= 16'h0000;
      disp_dp_q    <= 4'b1111;
      an_q         <= 4'b1111;
      bcd_q        <= 4'd0;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cnt_q        <= cnt_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      disp_dig_q   <= disp_dig_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.bcd        = bcd_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table vectors for reset and the first two frames, directed corner sequences,
// then random traffic against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;
  localparam int NVEC  = 67;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en_n;
    logic        ld;
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic        dp_n;
    logic        fd;
  } vec_t;

  vec_t       vt [NVEC];
  logic [3:0] an_pat  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] bcd_pat [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
  logic       dp_pat  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  // reference model state
  logic        m_act;
  int          m_t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pv;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic l,
                      input logic [15:0] d, input logic [3:0] p);
    reset         = r;
    bus.en_n      = e;
    bus.load      = l;
    bus.digits_in = d;
    bus.dp_in_n   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'h0, 4'hf);
  endtask

  task automatic chk_out(input string name, input logic [3:0] an, input logic [3:0] bcd,
                         input logic dp_n, input logic fd);
    chk({name, "_an"}, {12'h0, bus.an}, {12'h0, an});
    chk({name, "_bcd"}, {12'h0, bus.bcd}, {12'h0, bcd});
    chk({name, "_dp"}, {15'h0, bus.dp_n}, {15'h0, dp_n});
    chk({name, "_fd"}, {15'h0, bus.frame_done}, {15'h0, fd});
  endtask

  function automatic logic digit_visible(input int k, input logic [15:0] disp, input logic [3:0] dp);
`ifdef LEADING_ZERO_BLANK_EN
    return (k == 0) || !dp[k] || ((disp >> (4 * k)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input logic r, input logic e, input logic l,
                            input logic [15:0] d, input logic [3:0] p);
    logic boundary;
    logic [15:0] old_pend;
    logic [3:0]  old_pdp;
    logic        old_pv;
    if (r) begin
      m_act = 1'b0; m_t = 0; m_disp = 16'h0; m_dp = 4'hf;
      m_pend = 16'h0; m_pdp = 4'hf; m_pv = 1'b0;
      return;
    end
    boundary = !m_act || ((m_t % FRAME) == FRAME - 1);
    old_pend = m_pend; old_pdp = m_pdp; old_pv = m_pv;
    if (l) begin
      m_pend = d; m_pdp = p; m_pv = 1'b1;
    end
    if (boundary) begin
      if (l) begin
        m_disp = d; m_dp = p;
      end else if (old_pv) begin
        m_disp = old_pend; m_dp = old_pdp;
      end
      m_pv = 1'b0;
    end
    if (e) begin
      m_act = 1'b0; m_t = 0;
    end else if (!m_act) begin
      m_act = 1'b1; m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic model_check();
    int pos, k, w;
    logic [3:0] e_an;
    chk("rnd_noverlap", {15'h0, ($countones(~bus.an) > 1)}, 16'h0);
    if (!m_act) begin
      chk("rnd_idle_an", {12'h0, bus.an}, 16'h000f);
      chk("rnd_idle_dp", {15'h0, bus.dp_n}, 16'h0001);
      chk("rnd_idle_fd", {15'h0, bus.frame_done}, 16'h0000);
      return;
    end
    pos = m_t % FRAME;
    k   = pos / SLOT;
    w   = pos % SLOT;
    e_an = 4'hf;
    if (w >= BLANK && digit_visible(k, m_disp, m_dp)) e_an = ~(4'b0001 << k);
    chk("rnd_an", {12'h0, bus.an}, {12'h0, e_an});
    chk("rnd_bcd", {12'h0, bus.bcd}, (m_disp >> (4 * k)) & 16'h000f);
    chk("rnd_dp", {15'h0, bus.dp_n}, {15'h0, m_dp[k]});
    chk("rnd_fd", {15'h0, bus.frame_done}, {15'h0, (pos == FRAME - 1)});
  endtask

  initial begin
    logic r, e, l;
    logic [15:0] d;
    logic [3:0]  p;

    reset = 1'b1; bus.en_n = 1'b0; bus.load = 1'b0; bus.digits_in = 16'h0; bus.dp_in_n = 4'hf;

    for (int i = 0; i < 3; i++) begin
      vt[i].rst = 1'b1; vt[i].en_n = 1'b0; vt[i].ld = 1'b1;
      vt[i].dig = 16'h1234; vt[i].dp = 4'b1011;
      vt[i].an = 4'hf; vt[i].bcd = 4'h0; vt[i].dp_n = 1'b1; vt[i].fd = 1'b0;
    end
    for (int t = 0; t < 64; t++) begin
      int k, w;
      k = (t % FRAME) / SLOT;
      w = t % SLOT;
      vt[3+t].rst = 1'b0; vt[3+t].en_n = 1'b0; vt[3+t].ld = (t == 0);
      vt[3+t].dig = 16'h1234; vt[3+t].dp = 4'b1011;
      vt[3+t].an = (w < BLANK) ? 4'hf : an_pat[k];
      vt[3+t].bcd = bcd_pat[k]; vt[3+t].dp_n = dp_pat[k];
      vt[3+t].fd = ((t % FRAME) == FRAME - 1);
    end

    for (int i = 0; i < NVEC; i++) begin
      tick(vt[i].rst, vt[i].en_n, vt[i].ld, vt[i].dig, vt[i].dp);
      chk_out($sformatf("vec%0d", i), vt[i].an, vt[i].bcd, vt[i].dp_n, vt[i].fd);
    end

    // mid-frame load waits for the seam; load on the seam cycle applies at once
    adv(8);
    tick(1'b0, 1'b0, 1'b1, 16'h5678, 4'b1110);
    adv(10);
    chk_out("old_frame_s2", 4'b1011, 4'd2, 1'b0, 1'b0);
    adv(13);
    chk_out("old_frame_end", 4'b0111, 4'd1, 1'b1, 1'b1);
    adv(1);
    chk_out("new_frame_blank", 4'hf, 4'd8, 1'b0, 1'b0);
    adv(2);
    chk_out("new_frame_s0", 4'b1110, 4'd8, 1'b0, 1'b0);
    adv(8);
    chk_out("new_frame_s1", 4'b1101, 4'd7, 1'b1, 1'b0);
    adv(21);
    chk("seam_fd", {15'h0, bus.frame_done}, 16'h0001);
    tick(1'b0, 1'b0, 1'b1, 16'h9999, 4'hf);
    chk_out("seam_load_blank", 4'hf, 4'd9, 1'b1, 1'b0);
    adv(2);
    chk_out("seam_load_s0", 4'b1110, 4'd9, 1'b1, 1'b0);

    // disable during slot 2 SHOW, then resume from slot 0
    adv(17);
    chk("pre_dis_an", {12'h0, bus.an}, 16'h000b);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b0, 16'h0, 4'hf);
      chk($sformatf("dis_an%0d", i), {12'h0, bus.an}, 16'h000f);
      chk($sformatf("dis_fd%0d", i), {15'h0, bus.frame_done}, 16'h0);
      chk($sformatf("dis_dp%0d", i), {15'h0, bus.dp_n}, 16'h1);
    end
    adv(1);
    chk_out("resume_blank", 4'hf, 4'd9, 1'b1, 1'b0);
    adv(2);
    chk_out("resume_s0", 4'b1110, 4'd9, 1'b1, 1'b0);

    // reset pulse during slot 3 SHOW
    adv(25);
    chk_out("pre_rst_s3", 4'b0111, 4'd9, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 4'hf);
    chk_out("mid_rst", 4'hf, 4'd0, 1'b1, 1'b0);
    adv(1);
    chk_out("post_rst_blank", 4'hf, 4'd0, 1'b1, 1'b0);
    adv(2);
    chk_out("post_rst_s0", 4'b1110, 4'd0, 1'b1, 1'b0);

    // leading zeros: 0050, then 0000 with dp on digit 2
    tick(1'b0, 1'b1, 1'b0, 16'h0, 4'hf);
    tick(1'b0, 1'b0, 1'b1, 16'h0050, 4'hf);
    adv(2);
    chk_out("lz50_s0", 4'b1110, 4'd0, 1'b1, 1'b0);
    adv(8);
    chk_out("lz50_s1", 4'b1101, 4'd5, 1'b1, 1'b0);
    adv(8);
`ifdef LEADING_ZERO_BLANK_EN
    chk_out("lz50_s2", 4'hf, 4'd0, 1'b1, 1'b0);
`else
    chk_out("lz50_s2", 4'b1011, 4'd0, 1'b1, 1'b0);
`endif
    adv(8);
`ifdef LEADING_ZERO_BLANK_EN
    chk_out("lz50_s3", 4'hf, 4'd0, 1'b1, 1'b0);
`else
    chk_out("lz50_s3", 4'b0111, 4'd0, 1'b1, 1'b0);
`endif
    tick(1'b0, 1'b1, 1'b0, 16'h0, 4'hf);
    tick(1'b0, 1'b0, 1'b1, 16'h0000, 4'b1011);
    adv(2);
    chk_out("lz00_s0", 4'b1110, 4'd0, 1'b1, 1'b0);
    adv(8);
`ifdef LEADING_ZERO_BLANK_EN
    chk_out("lz00_s1", 4'hf, 4'd0, 1'b1, 1'b0);
`else
    chk_out("lz00_s1", 4'b1101, 4'd0, 1'b1, 1'b0);
`endif
    adv(8);
    chk_out("lz00_s2", 4'b1011, 4'd0, 1'b0, 1'b0);

    // random traffic against the model
    tick(1'b1, 1'b0, 1'b0, 16'h0, 4'hf);
    model_step(1'b1, 1'b0, 1'b0, 16'h0, 4'hf);
    e = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      r = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 119) == 0) e = ~e;
      l = ($urandom_range(0, 9) == 0);
      for (int n = 0; n < 4; n++) d[4*n +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      p = 4'($urandom) | 4'($urandom);
      tick(r, e, l, d, p);
      model_step(r, e, l, d, p);
      model_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
